mem_arbiter: RTL

Two-master arbiter and sequencer for the single synchronous memory port of the SLC-3 system.
- Masters: CPU (MAR/MDR path) and a secondary requester (DMA / program loader).
- Arbitrates requests and drives mem_ena, mem_wr_ena, mem_addr and mem_wdata.
- Counts out the memory read latency and returns data with a one-cycle ack to the winning master.
- Sits between cpu and the memory/MMIO subsystem.

---
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU port, secondary (DMA/loader) port and the
// single synchronous memory port. The slave modport is the arbiter's view;
// the master modport is the surrounding environment (requesters + memory).
interface mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ack;

  logic                  dma_req;
  logic                  dma_we;
  logic [DATA_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_ack;

  logic                  mem_ena;
  logic                  mem_wr_ena;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  grant_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_ena, mem_wr_ena, mem_addr, mem_wdata,
    output grant_dma
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_ena, mem_wr_ena, mem_addr, mem_wdata,
    input  grant_dma
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter/sequencer for the SLC-3 synchronous memory
// port. CPU and a secondary master (DMA / program loader) compete for the
// port; the winner's request is latched in IDLE, issued to memory, the read
// latency is counted out and a one-cycle ack is returned to the winner.
//
// Optional build macro ARB_CPU_PRIORITY_EN: when defined, the CPU always wins
// ties (fixed priority, secondary may starve). When undefined, ties are
// resolved round-robin against the last granted master.
module mem_arbiter #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
    $error("mem_arbiter: RD_LATENCY must be in 1..7");
  end

  localparam logic [2:0] WAIT_LAST = 3'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_ACK
  } state_t;

  state_t                state_q;
  logic                  we_q;
  logic                  grant_dma_q;
  logic [2:0]            cnt_q;
  logic                  cpu_ack_q;
  logic                  dma_ack_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;
  logic                  mem_ena_q;
  logic                  mem_wr_ena_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
`ifndef ARB_CPU_PRIORITY_EN
  logic                  last_dma_q;
`endif

  logic                  pick_dma_d;
  logic                  win_we_d;
  logic [DATA_WIDTH-1:0] win_addr_d;
  logic [DATA_WIDTH-1:0] win_wdata_d;

  // Select the winning master and its request fields for the IDLE sample
  always_comb begin
    pick_dma_d = 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
    pick_dma_d = bus.dma_req && !bus.cpu_req;
`else
    if (bus.cpu_req && bus.dma_req) begin
      pick_dma_d = !last_dma_q;
    end else begin
      pick_dma_d = bus.dma_req;
    end
`endif
    win_we_d    = pick_dma_d ? bus.dma_we    : bus.cpu_we;
    win_addr_d  = pick_dma_d ? bus.dma_addr  : bus.cpu_addr;
    win_wdata_d = pick_dma_d ? bus.dma_wdata : bus.cpu_wdata;
  end

  // Transaction sequencer; all outputs are registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      grant_dma_q  <= 1'b0;
      cnt_q        <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      mem_ena_q    <= 1'b0;
      mem_wr_ena_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifndef ARB_CPU_PRIORITY_EN
      last_dma_q   <= 1'b1;
`endif
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            state_q      <= S_ISSUE;
            we_q         <= win_we_d;
            grant_dma_q  <= pick_dma_d;
`ifndef ARB_CPU_PRIORITY_EN
            last_dma_q   <= pick_dma_d;
`endif
            mem_ena_q    <= 1'b1;
            mem_wr_ena_q <= win_we_d;
            mem_addr_q   <= win_addr_d;
            // read data path never exposes the requester's write data
            if (win_we_d) begin
              mem_wdata_q <= win_wdata_d;
            end
          end
        end
        S_ISSUE: begin
          mem_wr_ena_q <= 1'b0;
          if (we_q) begin
            state_q   <= S_ACK;
            mem_ena_q <= 1'b0;
            cpu_ack_q <= !grant_dma_q;
            dma_ack_q <= grant_dma_q;
          end else if (RD_LATENCY == 1) begin
            state_q <= S_CAPTURE;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= 3'd1;
          end
        end
        S_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_CAPTURE: begin
          state_q   <= S_ACK;
          mem_ena_q <= 1'b0;
          if (grant_dma_q) begin
            dma_rdata_q <= bus.mem_rdata;
            dma_ack_q   <= 1'b1;
          end else begin
            cpu_rdata_q <= bus.mem_rdata;
            cpu_ack_q   <= 1'b1;
          end
        end
        S_ACK: begin
          state_q     <= S_IDLE;
          grant_dma_q <= 1'b0;
          cnt_q       <= '0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.dma_ack    = dma_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.mem_ena    = mem_ena_q;
  assign bus.mem_wr_ena = mem_wr_ena_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.grant_dma  = grant_dma_q;

endmodule
